test_result_checker: RTL and testbench

Self-checking completion and result monitor for the cpu_cache benches.
- Snoops the CPU data-memory write port and keeps a shadow of the answer region.
- Detects the end-of-program sentinel write, then compares the shadow against golden words loaded by the bench, one word per cycle.
- Reports pass/fail, the error count, per-word mismatch detail and a cycle timeout.
- Generalises end-of-run checking to any answer base, word count, sentinel address and timeout.

---
 rtl/test_chk_pkg.sv | 21 ++
 rtl/chk_shadow_mem.sv | 32 +++
 rtl/test_result_checker.sv | 138 +++++++++++++
 tb/tb_test_result_checker.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/test_chk_pkg.sv
// Shared types and defaults for the end-of-run result checker.
package test_chk_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_CHECK   = 2'd1,
      ST_DONE    = 2'd2,
      ST_TIMEOUT = 2'd3
   } chk_state_t;

   localparam logic [31:0] DEF_ANSWER_BASE = 32'h0000_9000;
   localparam logic [31:0] DEF_DONE_ADDR   = 32'h0000_fffc;
   localparam logic [7:0]  DEF_DONE_VAL    = 8'hff;
   localparam int          DEF_TIMEOUT     = 100000;

   // Index width for n entries, never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/chk_shadow_mem.sv
// Shadow copy of the answer region: byte-strobed write port, synchronous
// clear on rst, one combinational read port.
module chk_shadow_mem
   import test_chk_pkg::*;
#(
   parameter  int NUM_WORDS = 100,
   localparam int IW        = idx_w(NUM_WORDS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [3:0]    we,
   input  logic [IW-1:0] widx,
   input  logic [31:0]   wdata,
   input  logic [IW-1:0] ridx,
   output logic [31:0]   rdata
);

   logic [31:0] mem [NUM_WORDS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_WORDS; i++) mem[i] <= '0;
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (we[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   assign rdata = mem[ridx];

endmodule

// File: rtl/test_result_checker.sv
// Snoops data-memory writes into a shadow of the answer region, waits for the
// sentinel write, then compares the shadow against golden words one per cycle.
module test_result_checker
   import test_chk_pkg::*;
#(
   parameter  int          ADDR_W      = 16,
   parameter  logic [31:0] ANSWER_BASE = DEF_ANSWER_BASE,
   parameter  int          NUM_WORDS   = 100,
   parameter  logic [31:0] DONE_ADDR   = DEF_DONE_ADDR,
   parameter  logic [7:0]  DONE_VAL    = DEF_DONE_VAL,
   parameter  int          TIMEOUT     = DEF_TIMEOUT,
   localparam int          IW          = idx_w(NUM_WORDS),
   localparam int          CW          = idx_w(NUM_WORDS + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        dm_we,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [31:0]       dm_wdata,
   input  logic              gold_we,
   input  logic [IW-1:0]     gold_idx,
   input  logic [31:0]       gold_data,
   input  logic [CW-1:0]     gold_num,
   output logic              done,
   output logic              pass,
   output logic              timeout,
   output logic [CW-1:0]     err_count,
   output logic              mis_valid,
   output logic [IW-1:0]     mis_idx,
   output logic [31:0]       mis_got,
   output logic [31:0]       mis_exp,
   output chk_state_t        dbg_state
);

   chk_state_t    state, state_next;
   logic [31:0]   cnt;
   logic [CW-1:0] n_q, n_in, err_next;
   logic [IW-1:0] idx_q, cmp_idx, sh_widx;
   logic [31:0]   cmp_got, cmp_exp, sh_rdata, addr32, word_off;
   logic          cmp_v, cmp_mis, in_region, sentinel, last_word;
   logic [3:0]    sh_we;
   logic [31:0]   gold_mem [NUM_WORDS];

   assign addr32    = 32'(dm_addr);
   assign in_region = (addr32 >= ANSWER_BASE) &&
                      (addr32 < ANSWER_BASE + 32'(4 * NUM_WORDS));
   assign word_off  = (addr32 - ANSWER_BASE) >> 2;
   assign sh_widx   = IW'(word_off);
   // The shadow only follows the program while it runs; it is frozen afterwards.
   assign sh_we     = (state == ST_RUN && in_region) ? dm_we : 4'b0000;
   assign sentinel  = dm_we[0] && (dm_addr == DONE_ADDR[ADDR_W-1:0]) &&
                      (dm_wdata[7:0] == DONE_VAL);
   assign n_in      = (32'(gold_num) > NUM_WORDS) ? CW'(NUM_WORDS) : gold_num;
   assign last_word = (32'(idx_q) + 32'd1 == 32'(n_q));
   assign cmp_mis   = cmp_v && (cmp_got != cmp_exp);
   assign timeout   = (state == ST_TIMEOUT);
   assign dbg_state = state;

   chk_shadow_mem #(.NUM_WORDS(NUM_WORDS)) u_shadow (
      .clk   (clk),
      .rst   (rst),
      .we    (sh_we),
      .widx  (sh_widx),
      .wdata (dm_wdata),
      .ridx  (idx_q),
      .rdata (sh_rdata)
   );

   always_ff @(posedge clk) begin
      if (gold_we && (32'(gold_idx) < NUM_WORDS)) gold_mem[gold_idx] <= gold_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_RUN;
      else     state <= state_next;
   end

   // Sentinel takes priority over a timeout landing in the same cycle.
   always_comb begin
      state_next = state;
      case (state)
         ST_RUN: begin
            if (sentinel)                         state_next = (n_in == '0) ? ST_DONE : ST_CHECK;
            else if (cnt == 32'(TIMEOUT - 1))     state_next = ST_TIMEOUT;
         end
         ST_CHECK: if (last_word) state_next = ST_DONE;
         default: ;
      endcase
   end

   always_comb begin
      err_next = err_count;
      if (cmp_mis && (32'(err_count) < NUM_WORDS)) err_next = err_count + CW'(1);
   end

   // Compare results pass through one register stage, so the final word's
   // mismatch and done become visible on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         n_q       <= '0;
         idx_q     <= '0;
         cmp_v     <= 1'b0;
         cmp_idx   <= '0;
         cmp_got   <= '0;
         cmp_exp   <= '0;
         mis_valid <= 1'b0;
         mis_idx   <= '0;
         mis_got   <= '0;
         mis_exp   <= '0;
         err_count <= '0;
         done      <= 1'b0;
         pass      <= 1'b0;
      end else begin
         if (state == ST_RUN) cnt <= cnt + 32'd1;
         if (state == ST_RUN && sentinel) begin
            n_q   <= n_in;
            idx_q <= '0;
         end else if (state == ST_CHECK) begin
            idx_q <= idx_q + IW'(1);
         end
         cmp_v     <= (state == ST_CHECK);
         cmp_idx   <= idx_q;
         cmp_got   <= sh_rdata;
         cmp_exp   <= gold_mem[idx_q];
         mis_valid <= cmp_mis;
         if (cmp_mis) begin
            mis_idx <= cmp_idx;
            mis_got <= cmp_got;
            mis_exp <= cmp_exp;
         end
         err_count <= err_next;
         done      <= (state == ST_DONE);
         pass      <= (state == ST_DONE) && (err_next == '0);
      end
   end

endmodule

// File: tb/tb_test_result_checker.sv
// Bench for test_result_checker: table vectors, directed corner sequences and
// randomized programs checked against a word/byte-level model of the answer region.
module tb_test_result_checker;
   import test_chk_pkg::*;

   localparam int          NW     = 6;
   localparam int          TO     = 50;
   localparam logic [15:0] BASE   = 16'h9000;
   localparam logic [15:0] DADDR  = 16'hfffc;
   localparam int unsigned BASE_I = 32'h9000;

   logic        clk, rst;
   logic [3:0]  dm_we;
   logic [15:0] dm_addr;
   logic [31:0] dm_wdata, gold_data;
   logic        gold_we;
   logic [2:0]  gold_idx, gold_num;
   logic        done, pass, timeout, mis_valid;
   logic [2:0]  err_count, mis_idx;
   logic [31:0] mis_got, mis_exp;
   chk_state_t  dbg_state;
   logic        d2_done, d2_pass, d2_timeout, d2_mis_valid;
   logic [2:0]  d2_err_count, d2_mis_idx;
   logic [31:0] d2_mis_got, d2_mis_exp;
   chk_state_t  d2_state;

   test_result_checker #(.ADDR_W(16), .ANSWER_BASE(32'h9000), .NUM_WORDS(NW),
      .DONE_ADDR(32'hfffc), .DONE_VAL(8'hff), .TIMEOUT(TO)) u_dut (
      .clk(clk), .rst(rst), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .gold_we(gold_we), .gold_idx(gold_idx), .gold_data(gold_data), .gold_num(gold_num),
      .done(done), .pass(pass), .timeout(timeout), .err_count(err_count),
      .mis_valid(mis_valid), .mis_idx(mis_idx), .mis_got(mis_got), .mis_exp(mis_exp),
      .dbg_state(dbg_state));

   // Sentinel placed on answer word 0 so one write is both sentinel and answer.
   test_result_checker #(.ADDR_W(16), .ANSWER_BASE(32'h9000), .NUM_WORDS(NW),
      .DONE_ADDR(32'h9000), .DONE_VAL(8'h07), .TIMEOUT(TO)) u_dut2 (
      .clk(clk), .rst(rst), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .gold_we(gold_we), .gold_idx(gold_idx), .gold_data(gold_data), .gold_num(gold_num),
      .done(d2_done), .pass(d2_pass), .timeout(d2_timeout), .err_count(d2_err_count),
      .mis_valid(d2_mis_valid), .mis_idx(d2_mis_idx), .mis_got(d2_mis_got),
      .mis_exp(d2_mis_exp), .dbg_state(d2_state));

   // clock/reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;
   logic [31:0] m_sh [NW];
   logic [31:0] m_gold [NW];
   logic [31:0] exp_q [$];

   typedef struct {
      logic [3:0]  we;
      logic [15:0] addr;
      logic [31:0] data;
      logic [31:0] gold0;
      logic [2:0]  gnum;
      logic        exp_pass;
      logic [2:0]  exp_err;
   } vec_t;
   vec_t tbl [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // driver tasks
   task automatic dm_wr(input logic [3:0] we, input logic [15:0] addr, input logic [31:0] data);
      int unsigned a, w;
      dm_we = we; dm_addr = addr; dm_wdata = data;
      tick();
      dm_we = 4'h0;
      a = 32'(addr);
      if (we != 4'h0 && a >= BASE_I && a < BASE_I + 4 * NW) begin
         w = (a - BASE_I) / 4;
         for (int b = 0; b < 4; b++) if (we[b]) m_sh[w][8*b +: 8] = data[8*b +: 8];
      end
   endtask

   task automatic load_gold(input logic [2:0] idx, input logic [31:0] data);
      gold_we = 1'b1; gold_idx = idx; gold_data = data;
      tick();
      gold_we = 1'b0;
      if (int'(idx) < NW) m_gold[idx] = data;
   endtask

   task automatic rst_on();
      rst = 1'b1; dm_we = 4'h0; gold_we = 1'b0;
      tick();
      for (int i = 0; i < NW; i++) m_sh[i] = '0;
   endtask

   task automatic rst_off();
      tick();
      rst = 1'b0;
      #1;
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_mis_valid", mis_valid, 0);
      chk("rst_err", err_count, 0);
      chk("rst_state", dbg_state, ST_RUN);
   endtask

   // Sentinel, then per-cycle scoreboard of mismatch pulses and completion.
   task automatic end_check(input logic [2:0] gnum, input bit junk);
      int n, errs, k;
      exp_q.delete();
      n = (int'(gnum) > NW) ? NW : int'(gnum);
      errs = 0;
      for (int i = 0; i < n; i++) if (m_sh[i] !== m_gold[i]) begin exp_q.push_back(i); errs++; end
      gold_num = gnum; dm_we = 4'b0001; dm_addr = DADDR; dm_wdata = 32'h0000_00ff;
      tick();
      dm_we = 4'h0;
      chk("state_after_sentinel", dbg_state, (n == 0) ? ST_DONE : ST_CHECK);
      for (int c = 1; c <= n + 1; c++) begin
         if (junk) begin
            dm_we = 4'hf; dm_addr = BASE + 16'(4 * $urandom_range(0, NW - 1)); dm_wdata = $urandom;
         end
         tick();
         dm_we = 4'h0;
         chk("done_timing", done, (c == n + 1));
         if (c >= 2) begin
            k = c - 2;
            if (exp_q.size() > 0 && exp_q[0] == k) begin
               void'(exp_q.pop_front());
               chk("mis_valid", mis_valid, 1);
               chk("mis_idx", mis_idx, k);
               chk("mis_got", mis_got, m_sh[k]);
               chk("mis_exp", mis_exp, m_gold[k]);
            end else begin
               chk("mis_valid", mis_valid, 0);
            end
         end else begin
            chk("mis_valid_early", mis_valid, 0);
         end
      end
      chk("err_count", err_count, errs);
      chk("pass", pass, (errs == 0));
      chk("timeout_quiet", timeout, 0);
      tick();
      chk("done_sticky", done, 1);
      chk("pass_sticky", pass, (errs == 0));
      chk("mis_valid_quiet", mis_valid, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; dm_we = 4'h0; dm_addr = '0; dm_wdata = '0;
      gold_we = 1'b0; gold_idx = '0; gold_data = '0; gold_num = '0;

      tbl[0] = '{4'b0010, 16'h9000, 32'h0000aa00, 32'h1122aa44, 3'd1, 1'b1, 3'd0};
      tbl[1] = '{4'b0000, 16'h9000, 32'hffffffff, 32'h11223344, 3'd1, 1'b1, 3'd0};
      tbl[2] = '{4'b1111, 16'h8ffc, 32'h00000000, 32'h11223344, 3'd1, 1'b1, 3'd0};
      tbl[3] = '{4'b1111, 16'h9000, 32'h00000055, 32'h11223344, 3'd1, 1'b0, 3'd1};
      tbl[4] = '{4'b1000, 16'h9000, 32'h99000000, 32'h99223344, 3'd1, 1'b1, 3'd0};
      tbl[5] = '{4'b1111, 16'h9000, 32'h00000000, 32'h00000005, 3'd0, 1'b1, 3'd0};
      tbl[6] = '{4'b0101, 16'h9000, 32'haabbccdd, 32'h11bb33dd, 3'd1, 1'b1, 3'd0};
      tbl[7] = '{4'b1111, 16'h9014, 32'h00000001, 32'h11223344, 3'd6, 1'b0, 3'd1};
      tbl[8] = '{4'b1111, 16'h9018, 32'h00000001, 32'h11223344, 3'd7, 1'b1, 3'd0};
      tbl[9] = '{4'b1111, 16'h9014, 32'h00000001, 32'h11223344, 3'd5, 1'b1, 3'd0};

      // Golden 1..4, matching answers, plus near-miss sentinels.
      rst_on();
      for (int i = 0; i < NW; i++) load_gold(3'(i), (i < 4) ? 32'(i + 1) : 32'h0);
      rst_off();
      for (int i = 0; i < 4; i++) dm_wr(4'hf, BASE + 16'(4 * i), 32'(i + 1));
      dm_wr(4'b0001, DADDR, 32'h0000_00fe);
      dm_wr(4'b1110, DADDR, 32'hffff_ffff);
      dm_wr(4'b0001, 16'hfff8, 32'h0000_00ff);
      chk("t1_no_false_sentinel", dbg_state, ST_RUN);
      end_check(3'd4, 1'b1);
      chk("t1_pass", pass, 1);

      // Word 2 corrupted.
      rst_on();
      for (int i = 0; i < NW; i++) load_gold(3'(i), (i < 4) ? 32'(i + 1) : 32'h0);
      load_gold(3'd7, 32'h1234_5678);
      rst_off();
      for (int i = 0; i < 4; i++) dm_wr(4'hf, BASE + 16'(4 * i), (i == 2) ? 32'hdead : 32'(i + 1));
      end_check(3'd4, 1'b0);
      chk("t2_err", err_count, 1);
      chk("t2_pass", pass, 0);

      // Table vectors: word 0 preloaded, one extra write, sentinel.
      for (int v = 0; v < 10; v++) begin
         rst_on();
         for (int i = 0; i < NW; i++) load_gold(3'(i), (i == 0) ? tbl[v].gold0 : 32'h0);
         rst_off();
         dm_wr(4'hf, BASE, 32'h1122_3344);
         dm_wr(tbl[v].we, tbl[v].addr, tbl[v].data);
         end_check(tbl[v].gnum, 1'b0);
         chk("tbl_pass", pass, tbl[v].exp_pass);
         chk("tbl_err", err_count, tbl[v].exp_err);
      end

      // Timeout with no sentinel; a late sentinel is ignored.
      rst_on();
      rst_off();
      for (int c = 1; c <= TO; c++) begin
         tick();
         if (c == TO - 1) chk("t4_timeout_early", timeout, 0);
      end
      chk("t4_timeout", timeout, 1);
      chk("t4_done", done, 0);
      dm_wr(4'b0001, DADDR, 32'h0000_00ff);
      tick();
      tick();
      chk("t4_timeout_sticky", timeout, 1);
      chk("t4_done_after_sentinel", done, 0);
      chk("t4_state", dbg_state, ST_TIMEOUT);

      // Sentinel write that is itself an answer write.
      rst_on();
      load_gold(3'd0, 32'h7);
      rst_off();
      gold_num = 3'd1;
      dm_wr(4'hf, BASE, 32'h7);
      chk("t5_state", d2_state, ST_CHECK);
      tick();
      chk("t5_done_early", d2_done, 0);
      tick();
      chk("t5_done", d2_done, 1);
      chk("t5_pass", d2_pass, 1);
      chk("t5_err", d2_err_count, 0);

      // Reset in the middle of CHECK.
      rst_on();
      for (int i = 0; i < NW; i++) load_gold(3'(i), 32'h0);
      rst_off();
      for (int i = 0; i < NW; i++) dm_wr(4'hf, BASE + 16'(4 * i), 32'h100 + 32'(i));
      gold_num = 3'd6; dm_we = 4'b0001; dm_addr = DADDR; dm_wdata = 32'hff;
      tick();
      dm_we = 4'h0;
      tick(); tick(); tick();
      chk("t6_pre_err", err_count, 2);
      chk("t6_pre_mis", mis_valid, 1);
      rst = 1'b1;
      #1;
      chk("t6_done", done, 0);
      chk("t6_pass", pass, 0);
      chk("t6_mis", mis_valid, 0);
      chk("t6_err", err_count, 0);
      chk("t6_state", dbg_state, ST_RUN);
      tick();
      for (int i = 0; i < NW; i++) m_sh[i] = '0;
      rst_off();
      end_check(3'd6, 1'b0);
      rst_on();
      rst_off();
      end_check(3'd0, 1'b0);

      // Randomized programs.
      for (int it = 0; it < 25; it++) begin
         int nw, r;
         logic [15:0] a;
         logic [3:0] we;
         rst_on();
         for (int i = 0; i < NW; i++) load_gold(3'(i), 32'($urandom_range(0, 3)));
         load_gold(3'($urandom_range(6, 7)), $urandom);
         rst_off();
         nw = $urandom_range(0, 12);
         for (int j = 0; j < nw; j++) begin
            r = $urandom_range(0, 9);
            a = (r < 8) ? BASE + 16'(4 * $urandom_range(0, NW - 1)) :
                (r == 8) ? BASE - 16'd4 : BASE + 16'(4 * NW);
            we = ($urandom_range(0, 1) == 1) ? 4'hf : 4'($urandom_range(0, 15));
            dm_wr(we, a, ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom);
            if ($urandom_range(0, 3) == 0) tick();
         end
         end_check(3'($urandom_range(0, 7)), 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
